// File: rtl/pc_pkg.sv
// Shared next-PC select encoding, default vectors and word-alignment helper
// for the fetch-stage program counter.
package pc_pkg;

   typedef enum logic [2:0] {
      PC_SEL_INC,
      PC_SEL_JR,
      PC_SEL_JUMP,
      PC_SEL_BRANCH,
      PC_SEL_EXC
   } pc_sel_e;

   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0180;
   localparam int          MAX_ADDR_W       = 64;

   function automatic logic [MAX_ADDR_W-1:0] word_align(input logic [MAX_ADDR_W-1:0] a);
      return a & ~MAX_ADDR_W'(3);
   endfunction

endpackage

// File: rtl/pc_if.sv
// Control/branch-side bundle for pc_unit: redirect requests in, PC and RAS status out.
// No handshake: every input is sampled on each rising edge unless stalled.
interface pc_if #(
   parameter int ADDR_W = 32
);
   logic              stall_in;
   logic              exception_in;
   logic              branch_taken_in;
   logic [ADDR_W-1:0] branch_target_in;
   logic              jump_in;
   logic [ADDR_W-1:0] jump_target_in;
   logic              call_in;
   logic              jr_in;
   logic [ADDR_W-1:0] jr_target_in;
   logic              ret_in;
   logic [ADDR_W-1:0] pc_out;
   logic [ADDR_W-1:0] pc_plus4_out;
   logic [ADDR_W-1:0] ras_top_out;
   logic              ras_empty_out;
   logic              ras_full_out;
   logic              ras_mispredict_out;
   logic              ras_overflow_out;
   logic              ras_underflow_out;

   modport master (
      output stall_in, exception_in, branch_taken_in, branch_target_in,
             jump_in, jump_target_in, call_in, jr_in, jr_target_in, ret_in,
      input  pc_out, pc_plus4_out, ras_top_out, ras_empty_out, ras_full_out,
             ras_mispredict_out, ras_overflow_out, ras_underflow_out
   );

   modport slave (
      input  stall_in, exception_in, branch_taken_in, branch_target_in,
             jump_in, jump_target_in, call_in, jr_in, jr_target_in, ret_in,
      output pc_out, pc_plus4_out, ras_top_out, ras_empty_out, ras_full_out,
             ras_mispredict_out, ras_overflow_out, ras_underflow_out
   );
endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack; push/pop take effect on the next edge, top/popped are
// combinational. Push when full overwrites the oldest entry; pop when empty is a no-op.
module ras_stack #(
   parameter int ADDR_W    = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] push_data,
   output logic [ADDR_W-1:0] top,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W-1:0] popped,
   output logic              overflow,
   output logic              underflow
);
   localparam int               PTR_W     = $clog2(RAS_DEPTH);
   localparam int               CNT_W     = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RAS_DEPTH);

   logic [ADDR_W-1:0] mem [RAS_DEPTH];
   logic [PTR_W-1:0]  ptr;
   logic [PTR_W-1:0]  ptr_inc;
   logic [CNT_W-1:0]  count;

   assign ptr_inc   = ptr + PTR_W'(1);
   assign empty     = (count == '0);
   assign full      = (count == DEPTH_CNT);
   assign popped    = mem[ptr];
   assign top       = empty ? '0 : mem[ptr];
   assign overflow  = push & full;
   assign underflow = pop & empty;

   // When full, ptr_inc lands on the oldest slot, so the wrap itself discards it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr   <= '0;
         count <= '0;
      end else if (push) begin
         ptr <= ptr_inc;
         if (!full)
            count <= count + CNT_W'(1);
      end else if (pop && !empty) begin
         ptr   <= ptr - PTR_W'(1);
         count <= count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[ptr_inc] <= push_data;
   end
endmodule

// File: rtl/pc_unit.sv
// Fetch-stage PC: fixed-priority next-PC select with one-cycle latency, stall hold
// (exception overrides stall) and a return-address stack with mispredict/error flags.
module pc_unit
   import pc_pkg::*;
#(
   parameter int          ADDR_W       = 32,
   parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
   parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR,
   parameter int          RAS_DEPTH    = 4
) (
   input  logic clk,
   input  logic reset_in,
   pc_if.slave  bus
);
   function automatic logic [ADDR_W-1:0] align_w(input logic [ADDR_W-1:0] a);
      return ADDR_W'(word_align(MAX_ADDR_W'(a)));
   endfunction

   localparam logic [ADDR_W-1:0] PC_RESET = align_w(ADDR_W'(RESET_VECTOR));
   localparam logic [ADDR_W-1:0] PC_EXC   = align_w(ADDR_W'(EXC_VECTOR));

   pc_sel_e           sel;
   logic              advance;
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_next;
   logic [ADDR_W-1:0] pc_plus4;
   logic [ADDR_W-1:0] jr_aligned;
   logic [ADDR_W-1:0] popped;
   logic              ras_empty;
   logic              ras_ovf;
   logic              ras_unf;
   logic              mis_q;
   logic              ovf_q;
   logic              unf_q;

   assign pc_plus4   = pc_q + ADDR_W'(4);
   assign jr_aligned = align_w(bus.jr_target_in);

   always_comb begin
      sel     = PC_SEL_INC;
      pc_next = pc_plus4;
      if (bus.exception_in)         sel = PC_SEL_EXC;
      else if (bus.branch_taken_in) sel = PC_SEL_BRANCH;
      else if (bus.jump_in)         sel = PC_SEL_JUMP;
      else if (bus.jr_in)           sel = PC_SEL_JR;

      advance = bus.exception_in | ~bus.stall_in;
      push    = advance & (sel == PC_SEL_JUMP) & bus.call_in;
      pop     = advance & (sel == PC_SEL_JR) & bus.ret_in;

      case (sel)
         PC_SEL_EXC:    pc_next = PC_EXC;
         PC_SEL_BRANCH: pc_next = align_w(bus.branch_target_in);
         PC_SEL_JUMP:   pc_next = align_w(bus.jump_target_in);
         PC_SEL_JR:     pc_next = jr_aligned;
         default:       pc_next = pc_plus4;
      endcase
   end

   ras_stack #(
      .ADDR_W    (ADDR_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (reset_in),
      .push      (push),
      .pop       (pop),
      .push_data (pc_plus4),
      .top       (bus.ras_top_out),
      .empty     (ras_empty),
      .full      (bus.ras_full_out),
      .popped    (popped),
      .overflow  (ras_ovf),
      .underflow (ras_unf)
   );

   // Mispredict is re-evaluated every edge, so it self-clears even during a stall.
   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         pc_q  <= PC_RESET;
         mis_q <= 1'b0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         if (advance)
            pc_q <= pc_next;
         mis_q <= pop & ~ras_empty & (jr_aligned != popped);
         ovf_q <= ovf_q | ras_ovf;
         unf_q <= unf_q | ras_unf;
      end
   end

   assign bus.pc_out             = pc_q;
   assign bus.pc_plus4_out       = pc_plus4;
   assign bus.ras_empty_out      = ras_empty;
   assign bus.ras_mispredict_out = mis_q;
   assign bus.ras_overflow_out   = ovf_q;
   assign bus.ras_underflow_out  = unf_q;
endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus randomized traffic against a queue-based
// reference model of the next-PC and return-stack rules.
module tb_pc_unit;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   pc_if #(.ADDR_W(32)) b32 ();
   pc_if #(.ADDR_W(16)) b16 ();

   pc_unit #(.ADDR_W(32), .RESET_VECTOR(32'h0040_0003), .EXC_VECTOR(32'h0000_0180), .RAS_DEPTH(4))
      dut32 (.clk(clk), .reset_in(rst), .bus(b32));
   pc_unit #(.ADDR_W(16), .RESET_VECTOR(32'h0000_FFFF), .EXC_VECTOR(32'h0000_0180), .RAS_DEPTH(4))
      dut16 (.clk(clk), .reset_in(rst), .bus(b16));

   // Reference model: PC value, stack as a queue (back = top), flags.
   logic [31:0] m_pc;
   logic [31:0] m_stk[$];
   logic        m_mis, m_ovf, m_unf;

   function automatic void model_reset();
      m_pc  = 32'h0040_0000;
      m_stk = {};
      m_mis = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endfunction

   function automatic void model_step(input logic st, exc, br, input logic [31:0] bt,
                                      input logic jmp, input logic [31:0] jt, input logic call,
                                      input logic jr, input logic [31:0] jrt, input logic ret);
      logic [31:0] p4;
      logic [31:0] e;
      p4    = m_pc + 32'd4;
      m_mis = 1'b0;
      if (exc) m_pc = 32'h180;
      else if (!st) begin
         if (br) m_pc = bt & 32'hFFFF_FFFC;
         else if (jmp) begin
            if (call) begin
               if (m_stk.size() == 4) begin
                  e = m_stk.pop_front();
                  m_ovf = 1'b1;
               end
               m_stk.push_back(p4);
            end
            m_pc = jt & 32'hFFFF_FFFC;
         end else if (jr) begin
            if (ret) begin
               if (m_stk.size() == 0) m_unf = 1'b1;
               else begin
                  e = m_stk.pop_back();
                  if (e != (jrt & 32'hFFFF_FFFC)) m_mis = 1'b1;
               end
            end
            m_pc = jrt & 32'hFFFF_FFFC;
         end else m_pc = p4;
      end
   endfunction

   task automatic cyc(input logic st, exc, br, input logic [31:0] bt,
                      input logic jmp, input logic [31:0] jt, input logic call,
                      input logic jr, input logic [31:0] jrt, input logic ret);
      b32.stall_in = st;        b32.exception_in = exc;
      b32.branch_taken_in = br; b32.branch_target_in = bt;
      b32.jump_in = jmp;        b32.jump_target_in = jt;   b32.call_in = call;
      b32.jr_in = jr;           b32.jr_target_in = jrt;    b32.ret_in = ret;
      @(posedge clk);
      model_step(st, exc, br, bt, jmp, jt, call, jr, jrt, ret);
      #1;
   endtask

   task automatic idle();   cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic branch(input logic [31:0] t); cyc(0, 0, 1, t, 0, 0, 0, 0, 0, 0); endtask
   task automatic jal(input logic [31:0] t);    cyc(0, 0, 0, 0, 1, t, 1, 0, 0, 0); endtask
   task automatic ret_to(input logic [31:0] t); cyc(0, 0, 0, 0, 0, 0, 0, 1, t, 1); endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      logic [31:0] exp;
      do_reset();
      checks++; if (b32.pc_out !== 32'h0040_0000) begin errors++; $display("FAIL reset_pc got %h want 00400000", b32.pc_out); end
      checks++; if ({b32.ras_empty_out, b32.ras_full_out, b32.ras_top_out} !== {2'b10, 32'h0}) begin errors++; $display("FAIL reset_ras got e%b f%b top %h want e1 f0 top 0", b32.ras_empty_out, b32.ras_full_out, b32.ras_top_out); end
      checks++; if ({b32.ras_mispredict_out, b32.ras_overflow_out, b32.ras_underflow_out} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {b32.ras_mispredict_out, b32.ras_overflow_out, b32.ras_underflow_out}); end
      checks++; if (b16.pc_out !== 16'hFFFC) begin errors++; $display("FAIL reset_pc16 got %h want fffc", b16.pc_out); end
      checks++; if (b16.pc_plus4_out !== 16'h0000) begin errors++; $display("FAIL plus4_wrap16 got %h want 0000", b16.pc_plus4_out); end
      for (int i = 1; i <= 3; i++) begin
         idle();
         exp = 32'h0040_0000 + 32'(4 * i);
         checks++; if (b32.pc_out !== exp) begin errors++; $display("FAIL idle_inc%0d got %h want %h", i, b32.pc_out, exp); end
         if (i == 1) begin
            checks++; if (b16.pc_out !== 16'h0000) begin errors++; $display("FAIL wrap16 got %h want 0000", b16.pc_out); end
         end
      end
   endtask

   task automatic test_priority();
      cyc(1, 1, 1, 32'h0000_4000, 1, 32'h0000_8000, 1, 0, 0, 0);
      checks++; if (b32.pc_out !== 32'h180) begin errors++; $display("FAIL exc_prio got %h want 00000180", b32.pc_out); end
      checks++; if (b32.ras_empty_out !== 1'b1) begin errors++; $display("FAIL exc_no_push got empty %b want 1", b32.ras_empty_out); end
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (b32.pc_out !== 32'h180) begin errors++; $display("FAIL stall_hold got %h want 00000180", b32.pc_out); end
      cyc(1, 0, 1, 32'h0000_9000, 1, 32'h0000_A000, 1, 0, 0, 0);
      checks++; if ({b32.pc_out, b32.ras_empty_out} !== {32'h180, 1'b1}) begin errors++; $display("FAIL stall_ignore got %h e%b want 00000180 e1", b32.pc_out, b32.ras_empty_out); end
   endtask

   task automatic test_call_return();
      branch(32'h0000_0201);
      checks++; if (b32.pc_out !== 32'h200) begin errors++; $display("FAIL branch_align got %h want 00000200", b32.pc_out); end
      jal(32'h0000_1000);
      checks++; if ({b32.pc_out, b32.ras_top_out} !== {32'h1000, 32'h204}) begin errors++; $display("FAIL jal got pc %h top %h want 00001000 00000204", b32.pc_out, b32.ras_top_out); end
      ret_to(32'h0000_0204);
      checks++; if ({b32.pc_out, b32.ras_empty_out, b32.ras_mispredict_out} !== {32'h204, 2'b10}) begin errors++; $display("FAIL ret_ok got pc %h e%b m%b want 00000204 e1 m0", b32.pc_out, b32.ras_empty_out, b32.ras_mispredict_out); end
      branch(32'h0000_0200);
      jal(32'h0000_1000);
      ret_to(32'h0000_0208);
      checks++; if ({b32.pc_out, b32.ras_mispredict_out} !== {32'h208, 1'b1}) begin errors++; $display("FAIL ret_mis got pc %h m%b want 00000208 m1", b32.pc_out, b32.ras_mispredict_out); end
      idle();
      checks++; if (b32.ras_mispredict_out !== 1'b0) begin errors++; $display("FAIL mis_pulse got %b want 0", b32.ras_mispredict_out); end
   endtask

   task automatic test_overflow();
      logic [31:0] exp;
      branch(32'h0000_0100);
      for (int i = 1; i <= 5; i++) begin
         jal(32'((i + 1) * 32'h100));
         if (i == 4) begin
            checks++; if ({b32.ras_full_out, b32.ras_overflow_out} !== 2'b10) begin errors++; $display("FAIL full4 got f%b o%b want f1 o0", b32.ras_full_out, b32.ras_overflow_out); end
         end
      end
      checks++; if ({b32.ras_full_out, b32.ras_overflow_out, b32.ras_top_out} !== {2'b11, 32'h504}) begin errors++; $display("FAIL overflow got f%b o%b top %h want f1 o1 00000504", b32.ras_full_out, b32.ras_overflow_out, b32.ras_top_out); end
      for (int k = 0; k < 4; k++) begin
         exp = 32'((5 - k) * 32'h100 + 4);
         checks++; if (b32.ras_top_out !== exp) begin errors++; $display("FAIL pop_order%0d got %h want %h", k, b32.ras_top_out, exp); end
         ret_to(exp);
         checks++; if (b32.ras_mispredict_out !== 1'b0) begin errors++; $display("FAIL pop_mis%0d got %b want 0", k, b32.ras_mispredict_out); end
      end
      checks++; if (b32.ras_empty_out !== 1'b1) begin errors++; $display("FAIL drained got empty %b want 1", b32.ras_empty_out); end
      ret_to(32'h0000_0777);
      checks++; if ({b32.pc_out, b32.ras_underflow_out, b32.ras_empty_out, b32.ras_mispredict_out} !== {32'h774, 3'b110}) begin errors++; $display("FAIL underflow got pc %h u%b e%b m%b want 00000774 u1 e1 m0", b32.pc_out, b32.ras_underflow_out, b32.ras_empty_out, b32.ras_mispredict_out); end
   endtask

   task automatic test_async_reset();
      jal(32'h0000_1000);
      jal(32'h0000_2000);
      checks++; if ({b32.ras_top_out, b32.ras_empty_out} !== {32'h1004, 1'b0}) begin errors++; $display("FAIL pre_reset got top %h e%b want 00001004 e0", b32.ras_top_out, b32.ras_empty_out); end
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #3;
      rst = 1'b1;
      #1;
      checks++; if (b32.pc_out !== 32'h0040_0000) begin errors++; $display("FAIL async_pc got %h want 00400000", b32.pc_out); end
      checks++; if ({b32.ras_empty_out, b32.ras_full_out, b32.ras_top_out} !== {2'b10, 32'h0}) begin errors++; $display("FAIL async_ras got e%b f%b top %h want e1 f0 0", b32.ras_empty_out, b32.ras_full_out, b32.ras_top_out); end
      checks++; if ({b32.ras_mispredict_out, b32.ras_overflow_out, b32.ras_underflow_out} !== 3'b000) begin errors++; $display("FAIL async_flags got %b want 000", {b32.ras_mispredict_out, b32.ras_overflow_out, b32.ras_underflow_out}); end
      rst = 1'b0;
      model_reset();
      b32.stall_in = 1'b0;
      idle();
      checks++; if (b32.pc_out !== 32'h0040_0004) begin errors++; $display("FAIL post_reset got %h want 00400004", b32.pc_out); end
   endtask

   task automatic test_random();
      logic        st, exc, br, jmp, call, jr, ret;
      logic [31:0] bt, jt, jrt, tp;
      for (int n = 0; n < 400; n++) begin
         st   = ($urandom_range(0, 4) == 0);
         exc  = ($urandom_range(0, 15) == 0);
         br   = ($urandom_range(0, 5) == 0);
         jmp  = ($urandom_range(0, 3) == 0);
         call = ($urandom_range(0, 1) == 0);
         jr   = ($urandom_range(0, 3) == 0);
         ret  = ($urandom_range(0, 2) != 0);
         bt   = $urandom();
         jt   = $urandom();
         jrt  = $urandom();
         if (m_stk.size() > 0 && $urandom_range(0, 1) == 0) begin
            tp  = m_stk[m_stk.size() - 1];
            jrt = tp | 32'($urandom_range(0, 3));
         end
         cyc(st, exc, br, bt, jmp, jt, call, jr, jrt, ret);
         tp = (m_stk.size() > 0) ? m_stk[m_stk.size() - 1] : 32'h0;
         checks++; if (b32.pc_out !== m_pc) begin errors++; $display("FAIL rnd_pc n=%0d got %h want %h", n, b32.pc_out, m_pc); end
         checks++; if (b32.pc_plus4_out !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_plus4 n=%0d got %h want %h", n, b32.pc_plus4_out, m_pc + 32'd4); end
         checks++; if (b32.ras_top_out !== tp) begin errors++; $display("FAIL rnd_top n=%0d got %h want %h", n, b32.ras_top_out, tp); end
         checks++; if ({b32.ras_empty_out, b32.ras_full_out} !== {m_stk.size() == 0, m_stk.size() == 4}) begin errors++; $display("FAIL rnd_occ n=%0d got e%b f%b want size %0d", n, b32.ras_empty_out, b32.ras_full_out, m_stk.size()); end
         checks++; if ({b32.ras_mispredict_out, b32.ras_overflow_out, b32.ras_underflow_out} !== {m_mis, m_ovf, m_unf}) begin errors++; $display("FAIL rnd_flags n=%0d got %b want %b", n, {b32.ras_mispredict_out, b32.ras_overflow_out, b32.ras_underflow_out}, {m_mis, m_ovf, m_unf}); end
      end
   endtask

   initial begin
      b16.stall_in = 0; b16.exception_in = 0; b16.branch_taken_in = 0; b16.branch_target_in = '0;
      b16.jump_in = 0;  b16.jump_target_in = '0; b16.call_in = 0;
      b16.jr_in = 0;    b16.jr_target_in = '0;   b16.ret_in = 0;
      b32.stall_in = 0; b32.exception_in = 0; b32.branch_taken_in = 0; b32.branch_target_in = '0;
      b32.jump_in = 0;  b32.jump_target_in = '0; b32.call_in = 0;
      b32.jr_in = 0;    b32.jr_target_in = '0;   b32.ret_in = 0;
      model_reset();
      @(posedge clk);
      #1;
      test_reset();
      test_priority();
      test_call_return();
      test_overflow();
      test_async_reset();
      do_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the MIPS fetch stage. It holds the architectural PC and selects the next PC by fixed priority among exception vector, branch, jump, jump-register and sequential increment. It honours a pipeline stall and includes a small return-address stack (RAS) that tracks call/return pairs and flags return-target mispredictions. It sits between the control/branch logic and the instruction memory address port.

## Interface
- `ADDR_W`, 32: PC width in bits; must be at least 8.
- `RESET_VECTOR`, 0: PC value loaded on reset.
- `EXC_VECTOR`, 32'h0000_0180: PC loaded on exception; truncated to `ADDR_W`.
- `RAS_DEPTH`, 4: number of RAS entries; a power of two, at least 2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_in`  in  1  asynchronous, active-high reset.
- `stall_in`  in  1  hold PC and RAS this cycle.
- `exception_in`  in  1  redirect to `EXC_VECTOR`.
- `branch_taken_in`  in  1  taken conditional branch.
- `branch_target_in`  in  ADDR_W  branch target.
- `jump_in`  in  1  direct jump (j/jal).
- `jump_target_in`  in  ADDR_W  jump target.
- `call_in`  in  1  qualifies `jump_in` as jal: push return address.
- `jr_in`  in  1  register jump.
- `jr_target_in`  in  ADDR_W  register-jump target.
- `ret_in`  in  1  qualifies `jr_in` as a return (jr $ra): pop RAS.
- `pc_out`  out  ADDR_W  current PC (registered).
- `pc_plus4_out`  out  ADDR_W  `pc_out` + 4, modulo 2^ADDR_W (combinational).
- `ras_top_out`  out  ADDR_W  top RAS entry; 0 when empty.
- `ras_empty_out`, `ras_full_out`  out  1  RAS occupancy flags.
- `ras_mispredict_out`  out  1  one-cycle pulse when an accepted return's target differs from the popped entry.
- `ras_overflow_out`, `ras_underflow_out`  out  1  sticky error flags, cleared only by reset.

## Operation
- Next-PC priority: exception > branch > jump > jr > increment.
- `exception_in` overrides `stall_in`. All other sources are ignored while stalled.
- All loaded targets have bits [1:0] forced to 0. The PC is always word-aligned.
- Push happens only when the jump source wins and `call_in` is high. The pushed value is the current `pc_plus4_out`.
- Pop happens only when the jr source wins and `ret_in` is high.
- `call_in` without `jump_in`, or `ret_in` without `jr_in`, has no effect.
- Exception, branch and stalled cycles never push or pop.
- Push when full:
  - Overwrite the oldest entry (circular buffer).
  - Count stays at `RAS_DEPTH`.
  - Set `ras_overflow_out`.
- Pop when empty:
  - PC still takes `jr_target_in`.
  - Count stays 0.
  - Set `ras_underflow_out`.
  - No mispredict pulse.
- Mispredict: on an accepted non-empty pop, compare the aligned `jr_target_in` against the popped entry. If they differ, `ras_mispredict_out` is 1 on the following cycle.
- Count, pointer and width rules:
  - Count is a `$clog2(RAS_DEPTH)+1` bit counter.
  - The top pointer wraps modulo `RAS_DEPTH`.
  - PC increment wraps silently from all-ones-aligned to 0.

## Timing
- Reset (asynchronous, immediate):
  - `pc_out` = `RESET_VECTOR` with bits [1:0] cleared.
  - RAS count = 0, so `ras_empty_out` = 1 and `ras_top_out` = 0.
  - `ras_full_out`, `ras_mispredict_out`, `ras_overflow_out` and `ras_underflow_out` = 0.
  - Reset during a stall or mid call/return sequence discards all stack content.
- Next-PC latency: one cycle. The selected value appears on `pc_out` after the next rising edge.
- `pc_plus4_out` and `ras_top_out` are combinational from registered state, valid in the same cycle.
- `ras_empty_out` and `ras_full_out` reflect the registered count.
- Mispredict pulse: registered; high for exactly the one cycle after the pop edge.
- Sticky flags assert on the edge of the offending operation.

## Structure
- Shared package `pc_pkg`:
  - Next-PC select enum: `PC_SEL_INC`, `PC_SEL_JR`, `PC_SEL_JUMP`, `PC_SEL_BRANCH`, `PC_SEL_EXC`.
  - Default vector constants.
  - An alignment mask function.
- Sub-module `ras_stack`, parametrised on `ADDR_W` and `RAS_DEPTH`:
  - Inputs: push, pop, push data.
  - Outputs: top, empty, full, popped value, overflow and underflow events.
- `pc_unit` contains the priority select, the PC register, the mispredict register and the sticky flags.

## Test plan
- Reset with `RESET_VECTOR`=0x0040_0003 → `pc_out`=0x0040_0000, `ras_empty_out`=1. Three idle cycles → 0x0040_0004, 0x0040_0008, 0x0040_000C.
- Same cycle: `exception_in`, `branch_taken_in`, `jump_in` and `stall_in` all high → `pc_out`=0x180. Next cycle `stall_in` alone → PC holds 0x180.
- Jal to 0x1000 from PC 0x200 → `pc_out`=0x1000, `ras_top_out`=0x204. Then jr+ret with target 0x204 → `pc_out`=0x204, empty, no mispredict. Repeat with target 0x208 → mispredict pulse for one cycle.
- `RAS_DEPTH`=4; five jal calls returning 0x104, 0x204, 0x304, 0x404, 0x504 → `ras_full_out`=1, overflow set. Four pops yield 0x504, 0x404, 0x304, 0x204. A fifth pop sets underflow and leaves count at 0.
- `ADDR_W`=16, PC 0xFFFC idle → `pc_out`=0x0000. Assert `reset_in` mid-cycle during a stall with 2 stack entries → outputs return to reset values before the next edge.
